// File: rtl/xyz_switch_allocator_pkg.sv
// Shared constants and types for the 3D-mesh switch allocator.
// Direction indices double as port indices and AddrDiff bit positions.
package xyz_switch_allocator_pkg;

  localparam int IDX_IP = 0;
  localparam int IDX_W  = 1;
  localparam int IDX_E  = 2;
  localparam int IDX_S  = 3;
  localparam int IDX_N  = 4;
  localparam int IDX_D  = 5;
  localparam int IDX_U  = 6;

  localparam int AD_W = 7;

  localparam int ROUTE_XYZ = 0;
  localparam int ROUTE_ZYX = 1;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } out_state_e;

endpackage

// File: rtl/rr_arbiter_n.sv
// N-way arbiter: search starts at ptr_i and wraps.
// FIXED forces the search to start at index 0.
module rr_arbiter_n #(
  parameter int N     = 7,
  parameter int IW    = 3,
  parameter bit FIXED = 1'b0
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  // First requester at or after the start index wins
  always_comb begin
    int  base;
    int  j;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    base  = FIXED ? 0 : int'(ptr_i);
    if (base >= N) base = 0;
    for (int k = 0; k < N; k++) begin
      j = base + k;
      if (j >= N) j = j - N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/xyz_switch_allocator.sv
// Switch allocator: dimension-ordered routing, one arbiter per
// output, wormhole lock held from head grant until tail transfer.
module xyz_switch_allocator
  import xyz_switch_allocator_pkg::*;
#(
  parameter int NUM_PORTS   = 7,
  parameter int ROUTE_ORDER = 0,
  parameter int ARB_MODE    = 0,
  parameter int SEL_W       = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_PORTS-1:0]       in_valid,
  input  logic [NUM_PORTS-1:0]       in_head,
  input  logic [NUM_PORTS-1:0]       in_tail,
  input  logic [NUM_PORTS*AD_W-1:0]  in_addrdiff,
  input  logic [NUM_PORTS-1:0]       out_ready,
  output logic [NUM_PORTS-1:0]       in_pop,
  output logic [NUM_PORTS-1:0]       out_push,
  output logic [NUM_PORTS*SEL_W-1:0] xbar_sel,
  output logic [NUM_PORTS-1:0]       out_busy
);

  localparam int NP = NUM_PORTS;

  function automatic logic [SEL_W-1:0] route_f(
    input logic [AD_W-1:0] ad
  );
    logic [SEL_W-1:0] r;
    r = SEL_W'(IDX_IP);
    if (ad[IDX_IP]) r = SEL_W'(IDX_IP);
    else if (ROUTE_ORDER == ROUTE_XYZ) begin
      if      (ad[IDX_W]) r = SEL_W'(IDX_W);
      else if (ad[IDX_E]) r = SEL_W'(IDX_E);
      else if (ad[IDX_S]) r = SEL_W'(IDX_S);
      else if (ad[IDX_N]) r = SEL_W'(IDX_N);
      else if (ad[IDX_D]) r = SEL_W'(IDX_D);
      else if (ad[IDX_U]) r = SEL_W'(IDX_U);
    end else begin
      if      (ad[IDX_D]) r = SEL_W'(IDX_D);
      else if (ad[IDX_U]) r = SEL_W'(IDX_U);
      else if (ad[IDX_S]) r = SEL_W'(IDX_S);
      else if (ad[IDX_N]) r = SEL_W'(IDX_N);
      else if (ad[IDX_W]) r = SEL_W'(IDX_W);
      else if (ad[IDX_E]) r = SEL_W'(IDX_E);
    end
    return r;
  endfunction

  function automatic logic [SEL_W-1:0] next_ptr(
    input logic [SEL_W-1:0] idx
  );
    return (idx == SEL_W'(NP - 1)) ? '0 : idx + 1'b1;
  endfunction

  out_state_e       state_q [NP];
  logic [SEL_W-1:0] owner_q [NP];
  logic [SEL_W-1:0] ptr_q   [NP];

  logic [SEL_W-1:0] route [NP];
  logic [NP-1:0]    req   [NP];
  logic [NP-1:0]    gnt   [NP];
  logic [SEL_W-1:0] gidx  [NP];
  logic [NP-1:0]    gany;
  logic [NP-1:0]    in_owns;
  logic [NP-1:0]    busy;
  logic [NP-1:0]    push;

  // Lock status per output and per input, from registered state
  always_comb begin
    in_owns = '0;
    for (int o = 0; o < NP; o++) begin
      busy[o] = (state_q[o] == ST_BUSY);
      if (busy[o]) in_owns[owner_q[o]] = 1'b1;
    end
  end

  // Route every head flit; idle inputs raise one request each
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      route[i] = route_f(in_addrdiff[i*AD_W +: AD_W]);
    end
    for (int o = 0; o < NP; o++) begin
      req[o] = '0;
      for (int i = 0; i < NP; i++) begin
        req[o][i] = in_valid[i] & in_head[i] & ~in_owns[i]
                  & (route[i] == SEL_W'(o));
      end
    end
  end

  for (genvar o = 0; o < NP; o++) begin : g_arb
    rr_arbiter_n #(
      .N     (NP),
      .IW    (SEL_W),
      .FIXED (ARB_MODE == ARB_FIXED)
    ) u_arb (
      .req_i (req[o]),
      .ptr_i (ptr_q[o]),
      .gnt_o (gnt[o]),
      .idx_o (gidx[o])
    );
    assign gany[o] = |gnt[o];
  end

  // A flit moves when the locked owner has data and output has room
  always_comb begin
    for (int o = 0; o < NP; o++) begin
      push[o] = busy[o] & in_valid[owner_q[o]] & out_ready[o];
    end
  end

  // Per-output lock FSM: grant in IDLE, release on tail transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < NP; o++) begin
        state_q[o] <= ST_IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < NP; o++) begin
        unique case (state_q[o])
          ST_IDLE: begin
            if (gany[o]) begin
              state_q[o] <= ST_BUSY;
              owner_q[o] <= gidx[o];
              if (ARB_MODE == ARB_RR) begin
                ptr_q[o] <= next_ptr(gidx[o]);
              end
            end
          end
          ST_BUSY: begin
            if (push[o] && in_tail[owner_q[o]]) begin
              state_q[o] <= ST_IDLE;
              owner_q[o] <= '0;
            end
          end
          default: state_q[o] <= ST_IDLE;
        endcase
      end
    end
  end

  // Strobes and crossbar selects
  always_comb begin
    in_pop   = '0;
    out_push = push;
    out_busy = busy;
    for (int o = 0; o < NP; o++) begin
      xbar_sel[o*SEL_W +: SEL_W] = busy[o] ? owner_q[o] : '0;
      if (push[o]) in_pop[owner_q[o]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_xyz_switch_allocator.sv
// Bench for xyz_switch_allocator: input FIFO model plus
// per-output scoreboard of (source, cycle) push events.
module tb_xyz_switch_allocator;
  import xyz_switch_allocator_pkg::*;

  localparam int NP = 7;
  localparam int SW = 3;

  typedef struct {
    bit         head;
    bit         tail;
    logic [6:0] ad;
  } flit_t;

  typedef struct {
    int src;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0]    in_valid;
  logic [NP-1:0]    in_head;
  logic [NP-1:0]    in_tail;
  logic [NP*7-1:0]  in_addrdiff;
  logic [NP-1:0]    out_ready;
  logic [NP-1:0]    pop_a  [3];
  logic [NP-1:0]    push_a [3];
  logic [NP-1:0]    busy_a [3];
  logic [NP*SW-1:0] sel_a  [3];

  int               sel_dut = 0;
  logic [NP-1:0]    pop_m, push_m, busy_m;
  logic [NP*SW-1:0] sel_m;

  always_comb begin
    pop_m  = pop_a[sel_dut];
    push_m = push_a[sel_dut];
    busy_m = busy_a[sel_dut];
    sel_m  = sel_a[sel_dut];
  end

  xyz_switch_allocator #(
    .NUM_PORTS(NP), .ROUTE_ORDER(ROUTE_XYZ),
    .ARB_MODE(ARB_RR), .SEL_W(SW)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_head(in_head), .in_tail(in_tail),
    .in_addrdiff(in_addrdiff), .out_ready(out_ready),
    .in_pop(pop_a[0]), .out_push(push_a[0]),
    .xbar_sel(sel_a[0]), .out_busy(busy_a[0])
  );

  xyz_switch_allocator #(
    .NUM_PORTS(NP), .ROUTE_ORDER(ROUTE_ZYX),
    .ARB_MODE(ARB_RR), .SEL_W(SW)
  ) u_zyx (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_head(in_head), .in_tail(in_tail),
    .in_addrdiff(in_addrdiff), .out_ready(out_ready),
    .in_pop(pop_a[1]), .out_push(push_a[1]),
    .xbar_sel(sel_a[1]), .out_busy(busy_a[1])
  );

  xyz_switch_allocator #(
    .NUM_PORTS(NP), .ROUTE_ORDER(ROUTE_XYZ),
    .ARB_MODE(ARB_FIXED), .SEL_W(SW)
  ) u_fix (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_head(in_head), .in_tail(in_tail),
    .in_addrdiff(in_addrdiff), .out_ready(out_ready),
    .in_pop(pop_a[2]), .out_push(push_a[2]),
    .xbar_sel(sel_a[2]), .out_busy(busy_a[2])
  );

  flit_t         fq   [NP][$];
  ev_t           expq [NP][$];
  ev_t           obsq [NP][$];
  logic [NP-1:0] rdy;
  logic [NP-1:0] pop_s;
  int            cyc;
  int            errors = 0;
  int            checks = 0;

  function automatic bit pending();
    for (int i = 0; i < NP; i++) if (fq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_pkt(input int i, input logic [6:0] ad,
                          input int len);
    for (int k = 0; k < len; k++) begin
      flit_t f;
      f.head = (k == 0);
      f.tail = (k == len - 1);
      f.ad   = ad;
      fq[i].push_back(f);
    end
  endtask

  task automatic expect_pkt(input int o, input int src,
                            input int c0, input int len);
    for (int k = 0; k < len; k++) begin
      ev_t e;
      e.src = src;
      e.cyc = c0 + k;
      expq[o].push_back(e);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      if (fq[i].size() > 0) begin
        in_valid[i] = 1'b1;
        in_head[i]  = fq[i][0].head;
        in_tail[i]  = fq[i][0].tail;
        in_addrdiff[i*7 +: 7] = fq[i][0].ad;
      end else begin
        in_valid[i] = 1'b0;
        in_head[i]  = 1'b0;
        in_tail[i]  = 1'b0;
        in_addrdiff[i*7 +: 7] = '0;
      end
    end
    out_ready = rdy;
  endtask

  task automatic sample();
    for (int o = 0; o < NP; o++) begin
      if (push_m[o]) begin
        ev_t e;
        e.src = int'(sel_m[o*SW +: SW]);
        e.cyc = cyc;
        obsq[o].push_back(e);
      end
    end
    pop_s = pop_m;
  endtask

  task automatic load();
    cyc = 0;
    drive();
    #1;
    sample();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) begin
      if (pop_s[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    end
    cyc++;
    drive();
    @(negedge clk);
    sample();
  endtask

  task automatic clear_q();
    for (int i = 0; i < NP; i++) begin
      fq[i].delete();
      expq[i].delete();
      obsq[i].delete();
    end
    pop_s = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_q();
    rdy = '1;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_q();
    rdy = '1;
    push_pkt(IDX_W, 7'(1 << IDX_E), 1);
    drive();
    #12;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (busy_a[d] !== '0) begin
        errors++;
        $display("FAIL reset_busy dut=%0d got %b expected 0",
                 d, busy_a[d]);
      end
      checks++;
      if (push_a[d] !== '0) begin
        errors++;
        $display("FAIL reset_push dut=%0d got %b expected 0",
                 d, push_a[d]);
      end
      checks++;
      if (pop_a[d] !== '0) begin
        errors++;
        $display("FAIL reset_pop dut=%0d got %b expected 0",
                 d, pop_a[d]);
      end
      checks++;
      if (sel_a[d] !== '0) begin
        errors++;
        $display("FAIL reset_sel dut=%0d got %h expected 0",
                 d, sel_a[d]);
      end
    end
  endtask

  task automatic test_single_flit();
    int n;
    do_reset();
    sel_dut = 0;
    push_pkt(IDX_W, 7'(1 << IDX_E), 1);
    push_pkt(IDX_W, 7'(1 << IDX_E), 1);
    expect_pkt(IDX_E, IDX_W, 1, 1);
    expect_pkt(IDX_E, IDX_W, 3, 1);
    load();
    checks++;
    if (busy_m !== '0) begin
      errors++;
      $display("FAIL single_c0_busy got %b expected 0", busy_m);
    end
    step();
    checks++;
    if (busy_m !== 7'(1 << IDX_E)) begin
      errors++;
      $display("FAIL single_c1_busy got %b expected %b",
               busy_m, 7'(1 << IDX_E));
    end
    checks++;
    if (push_m !== 7'(1 << IDX_E)) begin
      errors++;
      $display("FAIL single_c1_push got %b expected %b",
               push_m, 7'(1 << IDX_E));
    end
    checks++;
    if (pop_m !== 7'(1 << IDX_W)) begin
      errors++;
      $display("FAIL single_c1_pop got %b expected %b",
               pop_m, 7'(1 << IDX_W));
    end
    checks++;
    if (sel_m[IDX_E*SW +: SW] !== 3'(IDX_W)) begin
      errors++;
      $display("FAIL single_c1_sel got %0d expected %0d",
               sel_m[IDX_E*SW +: SW], IDX_W);
    end
    step();
    checks++;
    if (busy_m !== '0) begin
      errors++;
      $display("FAIL single_c2_idle got %b expected 0", busy_m);
    end
    n = 0;
    while (pending() && n < 20) begin step(); n++; end
    checks++;
    if (pending()) begin
      errors++;
      $display("FAIL single_timeout got %0d cycles expected drain", n);
    end
    repeat (2) step();
    for (int o = 0; o < NP; o++) begin
      while (expq[o].size() > 0) begin
        ev_t e, g;
        e = expq[o].pop_front();
        g.src = -1; g.cyc = -1;
        if (obsq[o].size() > 0) g = obsq[o].pop_front();
        checks++;
        if (g.src !== e.src || g.cyc !== e.cyc) begin
          errors++;
          $display("FAIL single_sb out=%0d got src=%0d cyc=%0d expected src=%0d cyc=%0d",
                   o, g.src, g.cyc, e.src, e.cyc);
        end
      end
      checks++;
      if (obsq[o].size() != 0) begin
        errors++;
        $display("FAIL single_extra out=%0d got %0d pushes expected 0",
                 o, obsq[o].size());
      end
    end
  endtask

  task automatic test_route_order();
    logic [6:0] ad;
    do_reset();
    sel_dut = 0;
    ad = '0;
    ad[IDX_E] = 1'b1; ad[IDX_N] = 1'b1; ad[IDX_U] = 1'b1;
    push_pkt(IDX_IP, ad, 1);
    load();
    step();
    checks++;
    if (busy_a[0] !== 7'(1 << IDX_E)) begin
      errors++;
      $display("FAIL order_xyz got %b expected %b",
               busy_a[0], 7'(1 << IDX_E));
    end
    checks++;
    if (busy_a[1] !== 7'(1 << IDX_U)) begin
      errors++;
      $display("FAIL order_zyx got %b expected %b",
               busy_a[1], 7'(1 << IDX_U));
    end
    step();
    ad = '0;
    ad[IDX_IP] = 1'b1; ad[IDX_E] = 1'b1;
    push_pkt(IDX_IP, ad, 1);
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (busy_a[d] !== 7'(1 << IDX_IP)) begin
        errors++;
        $display("FAIL order_ipbit dut=%0d got %b expected %b",
                 d, busy_a[d], 7'(1 << IDX_IP));
      end
    end
    step();
    push_pkt(IDX_IP, 7'd0, 1);
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (busy_a[d] !== 7'(1 << IDX_IP)) begin
        errors++;
        $display("FAIL order_zero dut=%0d got %b expected %b",
                 d, busy_a[d], 7'(1 << IDX_IP));
      end
    end
  endtask

  task automatic test_contention(input int dut_idx);
    int n;
    do_reset();
    sel_dut = dut_idx;
    push_pkt(IDX_W, 7'(1 << IDX_N), 3);
    push_pkt(IDX_W, 7'(1 << IDX_N), 3);
    push_pkt(IDX_S, 7'(1 << IDX_N), 3);
    push_pkt(IDX_S, 7'(1 << IDX_N), 3);
    push_pkt(IDX_D, 7'(1 << IDX_N), 3);
    push_pkt(IDX_D, 7'(1 << IDX_N), 3);
    if (dut_idx == 0) begin
      expect_pkt(IDX_N, IDX_W, 1, 3);
      expect_pkt(IDX_N, IDX_S, 5, 3);
      expect_pkt(IDX_N, IDX_D, 9, 3);
      expect_pkt(IDX_N, IDX_W, 13, 3);
      expect_pkt(IDX_N, IDX_S, 17, 3);
      expect_pkt(IDX_N, IDX_D, 21, 3);
    end else begin
      expect_pkt(IDX_N, IDX_W, 1, 3);
      expect_pkt(IDX_N, IDX_W, 5, 3);
      expect_pkt(IDX_N, IDX_S, 9, 3);
      expect_pkt(IDX_N, IDX_S, 13, 3);
      expect_pkt(IDX_N, IDX_D, 17, 3);
      expect_pkt(IDX_N, IDX_D, 21, 3);
    end
    load();
    n = 0;
    while (pending() && n < 60) begin step(); n++; end
    checks++;
    if (pending()) begin
      errors++;
      $display("FAIL contention_timeout dut=%0d got %0d cycles expected drain",
               dut_idx, n);
    end
    repeat (2) step();
    checks++;
    if (busy_m !== '0) begin
      errors++;
      $display("FAIL contention_idle dut=%0d got %b expected 0",
               dut_idx, busy_m);
    end
    for (int o = 0; o < NP; o++) begin
      while (expq[o].size() > 0) begin
        ev_t e, g;
        e = expq[o].pop_front();
        g.src = -1; g.cyc = -1;
        if (obsq[o].size() > 0) g = obsq[o].pop_front();
        checks++;
        if (g.src !== e.src || g.cyc !== e.cyc) begin
          errors++;
          $display("FAIL contention_sb dut=%0d out=%0d got src=%0d cyc=%0d expected src=%0d cyc=%0d",
                   dut_idx, o, g.src, g.cyc, e.src, e.cyc);
        end
      end
      checks++;
      if (obsq[o].size() != 0) begin
        errors++;
        $display("FAIL contention_extra out=%0d got %0d pushes expected 0",
                 o, obsq[o].size());
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    sel_dut = 0;
    push_pkt(IDX_W, 7'(1 << IDX_E), 4);
    expect_pkt(IDX_E, IDX_W, 1, 1);
    expect_pkt(IDX_E, IDX_W, 5, 3);
    load();
    step();
    rdy[IDX_E] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (push_m !== '0 || pop_m !== '0) begin
        errors++;
        $display("FAIL stall_strobe c=%0d got push=%b pop=%b expected 0",
                 cyc, push_m, pop_m);
      end
      checks++;
      if (busy_m !== 7'(1 << IDX_E)) begin
        errors++;
        $display("FAIL stall_lock c=%0d got %b expected %b",
                 cyc, busy_m, 7'(1 << IDX_E));
      end
    end
    rdy[IDX_E] = 1'b1;
    repeat (3) step();
    checks++;
    if (busy_m !== 7'(1 << IDX_E)) begin
      errors++;
      $display("FAIL stall_tail_lock got %b expected %b",
               busy_m, 7'(1 << IDX_E));
    end
    step();
    checks++;
    if (busy_m !== '0) begin
      errors++;
      $display("FAIL stall_release got %b expected 0", busy_m);
    end
    repeat (2) step();
    for (int o = 0; o < NP; o++) begin
      while (expq[o].size() > 0) begin
        ev_t e, g;
        e = expq[o].pop_front();
        g.src = -1; g.cyc = -1;
        if (obsq[o].size() > 0) g = obsq[o].pop_front();
        checks++;
        if (g.src !== e.src || g.cyc !== e.cyc) begin
          errors++;
          $display("FAIL stall_sb out=%0d got src=%0d cyc=%0d expected src=%0d cyc=%0d",
                   o, g.src, g.cyc, e.src, e.cyc);
        end
      end
      checks++;
      if (obsq[o].size() != 0) begin
        errors++;
        $display("FAIL stall_extra out=%0d got %0d pushes expected 0",
                 o, obsq[o].size());
      end
    end
  endtask

  task automatic test_wormhole();
    int n;
    do_reset();
    sel_dut = 0;
    push_pkt(IDX_W, 7'(1 << IDX_E), 4);
    expect_pkt(IDX_E, IDX_W, 1, 4);
    expect_pkt(IDX_E, IDX_S, 6, 1);
    expect_pkt(IDX_D, IDX_N, 3, 2);
    load();
    step();
    push_pkt(IDX_S, 7'(1 << IDX_E), 1);
    push_pkt(IDX_N, 7'(1 << IDX_D), 2);
    step();
    checks++;
    if (busy_m !== 7'(1 << IDX_E)) begin
      errors++;
      $display("FAIL worm_c2_busy got %b expected %b",
               busy_m, 7'(1 << IDX_E));
    end
    step();
    checks++;
    if (busy_m !== 7'((1 << IDX_E) | (1 << IDX_D))) begin
      errors++;
      $display("FAIL worm_c3_busy got %b expected %b",
               busy_m, 7'((1 << IDX_E) | (1 << IDX_D)));
    end
    n = 0;
    while (pending() && n < 30) begin step(); n++; end
    checks++;
    if (pending()) begin
      errors++;
      $display("FAIL worm_timeout got %0d cycles expected drain", n);
    end
    repeat (2) step();
    for (int o = 0; o < NP; o++) begin
      while (expq[o].size() > 0) begin
        ev_t e, g;
        e = expq[o].pop_front();
        g.src = -1; g.cyc = -1;
        if (obsq[o].size() > 0) g = obsq[o].pop_front();
        checks++;
        if (g.src !== e.src || g.cyc !== e.cyc) begin
          errors++;
          $display("FAIL worm_sb out=%0d got src=%0d cyc=%0d expected src=%0d cyc=%0d",
                   o, g.src, g.cyc, e.src, e.cyc);
        end
      end
      checks++;
      if (obsq[o].size() != 0) begin
        errors++;
        $display("FAIL worm_extra out=%0d got %0d pushes expected 0",
                 o, obsq[o].size());
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    sel_dut = 0;
    push_pkt(IDX_W, 7'(1 << IDX_E), 4);
    load();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy_m !== '0 || push_m !== '0) begin
      errors++;
      $display("FAIL rstmid_busy_push got busy=%b push=%b expected 0",
               busy_m, push_m);
    end
    checks++;
    if (pop_m !== '0 || sel_m !== '0) begin
      errors++;
      $display("FAIL rstmid_pop_sel got pop=%b sel=%h expected 0",
               pop_m, sel_m);
    end
    clear_q();
    drive();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_pkt(IDX_S, 7'(1 << IDX_E), 1);
    push_pkt(IDX_W, 7'(1 << IDX_E), 1);
    expect_pkt(IDX_E, IDX_W, 1, 1);
    expect_pkt(IDX_E, IDX_S, 3, 1);
    load();
    n = 0;
    while (pending() && n < 20) begin step(); n++; end
    checks++;
    if (pending()) begin
      errors++;
      $display("FAIL rstmid_timeout got %0d cycles expected drain", n);
    end
    repeat (2) step();
    for (int o = 0; o < NP; o++) begin
      while (expq[o].size() > 0) begin
        ev_t e, g;
        e = expq[o].pop_front();
        g.src = -1; g.cyc = -1;
        if (obsq[o].size() > 0) g = obsq[o].pop_front();
        checks++;
        if (g.src !== e.src || g.cyc !== e.cyc) begin
          errors++;
          $display("FAIL rstmid_sb out=%0d got src=%0d cyc=%0d expected src=%0d cyc=%0d",
                   o, g.src, g.cyc, e.src, e.cyc);
        end
      end
      checks++;
      if (obsq[o].size() != 0) begin
        errors++;
        $display("FAIL rstmid_extra out=%0d got %0d pushes expected 0",
                 o, obsq[o].size());
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rdy = '1;
    pop_s = '0;
    cyc = 0;
    test_reset();
    test_single_flit();
    test_route_order();
    test_contention(0);
    test_contention(2);
    test_backpressure();
    test_wormhole();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
